trap_ctrl: RTL and testbench
============================

# trap_ctrl

Pipeline-side trap sequencer that sits directly upstream of the CSR file. It watches the EX stage for synchronous exceptions and `mret`/`sret`, prioritises them, and freezes and flushes the pipeline. After waiting for outstanding memory traffic to drain, it issues a single-cycle `trap_take`/`mret`/`sret` commit to the CSR block, then redirects fetch to the `trap_vector`/`ret_addr` the CSR block returns.

## Interface
- `DRAIN_TIMEOUT`, 255: max cycles spent in DRAIN before committing regardless of `mem_busy`; 8-bit range, 0 = commit on first DRAIN cycle.
- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-high
- `ex_valid`  in  1  EX stage holds a real instruction
- `ex_pc`  in  32  PC of EX instruction
- `exc_imisalign`, `exc_illegal`, `exc_ebreak`, `exc_ecall`, `exc_lmisalign`, `exc_smisalign`  in  1 each  exception flags for EX instruction
- `ex_mret`, `ex_sret`  in  1 each  EX instruction is MRET/SRET
- `current_priv`  in  2  current privilege (00 U, 01 S, 11 M)
- `mem_busy`  in  1  LSU has an outstanding access
- `trap_vector`, `ret_addr`  in  32 each  from CSR block
- `busy`, `stall`, `flush`  out  1 each  sequencer active / freeze pipeline / kill IF–EX
- `trap_take`, `mret`, `sret`  out  1 each  one-cycle commit strobes to CSR
- `trap_pc`, `trap_cause`  out  32 each  captured PC and cause to CSR
- `redirect_valid`  out  1  one-cycle fetch redirect
- `redirect_pc`  out  32  redirect target

## Operation
- States: IDLE, DRAIN, COMMIT, REDIRECT.
- IDLE, `ex_valid`=1, any event: capture on the clock edge, then go to DRAIN.
- Event priority, highest first: imisalign (0), illegal (2), ebreak (3), ecall (8+`current_priv`: U=8, S=9, M=11), lmisalign (4), smisalign (6), then mret, then sret.
- `mret` with `current_priv`≠11 and `sret` with `current_priv`=00 are converted to illegal (cause 2).
- Capture loads `trap_pc`←`ex_pc`, `trap_cause`, and a kind register (trap/mret/sret). Flags with `ex_valid`=0 are ignored.
- DRAIN: the 8-bit counter starts at 0. Go to COMMIT when `mem_busy`=0 or counter==`DRAIN_TIMEOUT`; otherwise increment the counter.
- COMMIT: exactly one of `trap_take`/`mret`/`sret` is high, per kind. The target is registered at the COMMIT edge: `ret_addr` for mret/sret, `{trap_vector[31:2],2'b00}` for traps.
- REDIRECT: `redirect_valid`=1 for one cycle, `redirect_pc` holds the registered target. Next state is IDLE.
- `busy`, `stall` and `flush` are high in DRAIN, COMMIT and REDIRECT.
- All EX inputs are ignored outside IDLE.
- `trap_pc`/`trap_cause` hold their value until the next capture.

## Timing
- Exception on EX in cycle N, `mem_busy`=0: DRAIN in N+1, COMMIT in N+2, REDIRECT in N+3, IDLE in N+4.
- Each extra busy cycle adds one cycle of latency. The maximum DRAIN length is `DRAIN_TIMEOUT`+1 cycles.
- Commit strobes and `redirect_valid` never overlap and are never high for 2 consecutive cycles.
- Reset values: state IDLE; every output and the counter are 0.
- Reset asserted in any state: outputs clear immediately (asynchronously) and no strobe completes.
- Back-to-back events: an event present in the IDLE cycle right after REDIRECT is captured normally.

## Configuration
- `TRAP_IRQ_EN` defined adds three inputs: `irq_ext`, `irq_timer`, `irq_enable` (1 each).
  - In IDLE with `ex_valid`=1, no sync exception, and `irq_enable`=1, a pending irq is captured with `trap_pc`=`ex_pc`.
  - Cause is 0x8000000B for ext, which has priority over 0x80000007 for timer. Interrupts have priority over mret/sret.
  - If `trap_vector[1:0]`=01 and cause bit 31=1, the target is `{trap_vector[31:2],2'b00}`+4×cause[4:0].
- `TRAP_IRQ_EN` undefined: the three ports are absent, interrupts are never taken, and vectored mode is ignored.

## Test plan
- Illegal at `ex_pc`=0x100, M-mode, `trap_vector`=0x200, `mem_busy`=0: `trap_take` at N+2 with `trap_pc`=0x100, cause 2; redirect to 0x200 at N+3.
- ecall in U with `exc_lmisalign` also set: cause 8.
- `mret` in M, `ret_addr`=0x344: `mret` strobe at N+2; redirect 0x344.
- `sret` in U: `trap_take` with cause 2, no `sret` strobe.
- `mem_busy` held high for 10 cycles, `DRAIN_TIMEOUT`=4: COMMIT after 5 DRAIN cycles.
- `rst` pulsed during DRAIN: all outputs 0 immediately; no `trap_take`.
- `TRAP_IRQ_EN`: `irq_timer`=1, `irq_enable`=1, `trap_vector`=0x201: cause 0x80000007, redirect 0x21C.

Source files
------------

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : trap_ctrl
// Purpose  : EX-stage trap sequencer. It captures, drains, commits to the CSR
//            file, and redirects fetch. Optional interrupts: TRAP_IRQ_EN.
// Revision : 1.0 - initial release
// ============================================================================
module trap_ctrl #(
  parameter logic [7:0] DRAIN_TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        exc_imisalign,
  input  logic        exc_illegal,
  input  logic        exc_ebreak,
  input  logic        exc_ecall,
  input  logic        exc_lmisalign,
  input  logic        exc_smisalign,
  input  logic        ex_mret,
  input  logic        ex_sret,
  input  logic [1:0]  current_priv,
  input  logic        mem_busy,
  input  logic [31:0] trap_vector,
  input  logic [31:0] ret_addr,
`ifdef TRAP_IRQ_EN
  input  logic        irq_ext,
  input  logic        irq_timer,
  input  logic        irq_enable,
`endif
  output logic        busy,
  output logic        stall,
  output logic        flush,
  output logic        trap_take,
  output logic        mret,
  output logic        sret,
  output logic [31:0] trap_pc,
  output logic [31:0] trap_cause,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam logic [1:0] c_IDLE     = 2'd0;
  localparam logic [1:0] c_DRAIN    = 2'd1;
  localparam logic [1:0] c_COMMIT   = 2'd2;
  localparam logic [1:0] c_REDIRECT = 2'd3;

  localparam logic [1:0] c_KIND_TRAP = 2'd0;
  localparam logic [1:0] c_KIND_MRET = 2'd1;
  localparam logic [1:0] c_KIND_SRET = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  r_kind;
  logic [7:0]  r_cnt;
  logic        w_event;
  logic [1:0]  w_kind;
  logic [31:0] w_cause;
  logic [31:0] w_target;

  // Priority decode; an xRET from an insufficient privilege becomes illegal.
  always_comb begin
    w_event = 1'b1;
    w_kind  = c_KIND_TRAP;
    w_cause = 32'd0;
    if (exc_imisalign) begin
      w_cause = 32'd0;
    end else if (exc_illegal) begin
      w_cause = 32'd2;
    end else if (exc_ebreak) begin
      w_cause = 32'd3;
    end else if (exc_ecall) begin
      w_cause = {28'd0, 2'b10, current_priv};
    end else if (exc_lmisalign) begin
      w_cause = 32'd4;
    end else if (exc_smisalign) begin
      w_cause = 32'd6;
`ifdef TRAP_IRQ_EN
    end else if (irq_enable && irq_ext) begin
      w_cause = 32'h8000_000B;
    end else if (irq_enable && irq_timer) begin
      w_cause = 32'h8000_0007;
`endif
    end else if (ex_mret) begin
      if (current_priv == 2'b11) w_kind  = c_KIND_MRET;
      else                       w_cause = 32'd2;
    end else if (ex_sret) begin
      if (current_priv != 2'b00) w_kind  = c_KIND_SRET;
      else                       w_cause = 32'd2;
    end else begin
      w_event = 1'b0;
    end
  end

  always_comb begin
    w_target = ret_addr;
    if (r_kind == c_KIND_TRAP) begin
      w_target = trap_vector & 32'hFFFF_FFFC;
`ifdef TRAP_IRQ_EN
      if (trap_vector[1:0] == 2'b01 && trap_cause[31])
        w_target = (trap_vector & 32'hFFFF_FFFC) + {25'd0, trap_cause[4:0], 2'b00};
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= c_IDLE;
      r_kind      <= c_KIND_TRAP;
      r_cnt       <= 8'd0;
      trap_pc     <= 32'd0;
      trap_cause  <= 32'd0;
      redirect_pc <= 32'd0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (ex_valid && w_event) begin
            trap_pc    <= ex_pc;
            trap_cause <= w_cause;
            r_kind     <= w_kind;
            r_cnt      <= 8'd0;
            r_state    <= c_DRAIN;
          end
        end
        c_DRAIN: begin
          if (!mem_busy || r_cnt == DRAIN_TIMEOUT) r_state <= c_COMMIT;
          else                                     r_cnt   <= r_cnt + 8'd1;
        end
        c_COMMIT: begin
          redirect_pc <= w_target;
          r_state     <= c_REDIRECT;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so an async reset kills them at once.
  always_comb begin
    busy           = (r_state != c_IDLE);
    stall          = busy;
    flush          = busy;
    trap_take      = (r_state == c_COMMIT) && (r_kind == c_KIND_TRAP);
    mret           = (r_state == c_COMMIT) && (r_kind == c_KIND_MRET);
    sret           = (r_state == c_COMMIT) && (r_kind == c_KIND_SRET);
    redirect_valid = (r_state == c_REDIRECT);
  end

endmodule
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_trap_ctrl
// Purpose  : Scoreboard bench for trap_ctrl (commit/redirect ordering, causes).
// Revision : 1.0 - initial release
// ============================================================================
module tb_trap_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_pc = '0;
  logic        exc_imisalign = 0, exc_illegal = 0, exc_ebreak = 0;
  logic        exc_ecall = 0, exc_lmisalign = 0, exc_smisalign = 0;
  logic        ex_mret = 0, ex_sret = 0;
  logic [1:0]  current_priv = 2'b11;
  logic        mem_busy = 1'b0;
  logic [31:0] trap_vector = '0, ret_addr = '0;
  logic        irq_ext = 0, irq_timer = 0, irq_enable = 0;
  logic        busy, stall, flush, trap_take, mret, sret, redirect_valid;
  logic [31:0] trap_pc, trap_cause, redirect_pc;

  trap_ctrl #(.DRAIN_TIMEOUT(8'(TO))) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .exc_imisalign(exc_imisalign), .exc_illegal(exc_illegal), .exc_ebreak(exc_ebreak),
    .exc_ecall(exc_ecall), .exc_lmisalign(exc_lmisalign), .exc_smisalign(exc_smisalign),
    .ex_mret(ex_mret), .ex_sret(ex_sret), .current_priv(current_priv), .mem_busy(mem_busy),
    .trap_vector(trap_vector), .ret_addr(ret_addr),
`ifdef TRAP_IRQ_EN
    .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_enable(irq_enable),
`endif
    .busy(busy), .stall(stall), .flush(flush), .trap_take(trap_take), .mret(mret),
    .sret(sret), .trap_pc(trap_pc), .trap_cause(trap_cause),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hit;
    logic [2:0]  strobe;  // {sret, mret, trap_take}
    logic [31:0] pc;
    logic [31:0] cause;
    logic [31:0] target;
    int          commit_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   last_commit = -10;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference behaviour: priority, privilege conversion and redirect target.
  function automatic exp_t model(input logic [5:0] exc, input logic m, input logic s,
                                 input logic [1:0] priv, input logic [31:0] pc,
                                 input logic [31:0] tv, input logic [31:0] ra,
                                 input logic [2:0] irq);
    exp_t e;
    e.hit = 1'b1; e.strobe = 3'b001; e.pc = pc; e.cause = 32'd0; e.commit_cyc = 0;
    if      (exc[0]) e.cause = 0;
    else if (exc[1]) e.cause = 2;
    else if (exc[2]) e.cause = 3;
    else if (exc[3]) e.cause = 8 + 32'(priv);
    else if (exc[4]) e.cause = 4;
    else if (exc[5]) e.cause = 6;
`ifdef TRAP_IRQ_EN
    else if (irq[2] && irq[1]) e.cause = 32'h8000000B;
    else if (irq[2] && irq[0]) e.cause = 32'h80000007;
`endif
    else if (m) begin if (priv == 2'b11) e.strobe = 3'b010; else e.cause = 2; end
    else if (s) begin if (priv != 2'b00) e.strobe = 3'b100; else e.cause = 2; end
    else e.hit = 1'b0;
    if (e.strobe == 3'b001) begin
      e.target = {tv[31:2], 2'b00};
`ifdef TRAP_IRQ_EN
      if (tv[1:0] == 2'b01 && e.cause[31]) e.target = e.target + 32'(e.cause[4:0]) * 4;
`endif
    end else begin
      e.target = ra;
    end
    if (irq == 3'b111) e.target = e.target;  // keep all irq bits referenced
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (trap_take || mret || sret) begin
        if (sb.size() == 0) check("unexpected_commit", {29'd0, sret, mret, trap_take}, 32'd0);
        else begin
          check("commit_kind", {29'd0, sret, mret, trap_take}, {29'd0, sb[0].strobe});
          check("trap_pc", trap_pc, sb[0].pc);
          check("trap_cause", trap_cause, sb[0].cause);
          check("commit_cycle", 32'(cyc), 32'(sb[0].commit_cyc));
        end
        last_commit = cyc;
      end
      if (redirect_valid) begin
        if (sb.size() == 0) check("unexpected_redirect", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("redirect_pc", redirect_pc, e.target);
          check("redirect_cycle", 32'(cyc), 32'(last_commit + 1));
          check("no_strobe_in_redirect", {29'd0, sret, mret, trap_take}, 32'd0);
        end
      end
    end
  end

  // Called right after a posedge; the event sits in EX for exactly that cycle.
  task automatic send(input logic v, input logic [5:0] exc, input logic m, input logic s,
                      input logic [1:0] priv, input logic [31:0] pc, input logic [31:0] tv,
                      input logic [31:0] ra, input int busy_n, input logic [2:0] irq);
    exp_t e;
    int   ext;
    e   = model(exc, m, s, priv, pc, tv, ra, irq);
    ext = (busy_n < TO) ? busy_n : TO;
    ex_valid = v; ex_pc = pc; current_priv = priv; trap_vector = tv; ret_addr = ra;
    {exc_smisalign, exc_lmisalign, exc_ecall, exc_ebreak, exc_illegal, exc_imisalign} = exc;
    ex_mret = m; ex_sret = s; {irq_enable, irq_ext, irq_timer} = irq;
    mem_busy = (busy_n > 0);
    if (v && e.hit) begin
      e.commit_cyc = cyc + 2 + ext;
      sb.push_back(e);
    end
    for (int j = 1; j < 300 && (j == 1 || sb.size() != 0); j++) begin
      @(posedge clk); #1;
      if (j == 1) begin
        // Junk in EX during DRAIN must not be recaptured.
        ex_valid = 1'b1; ex_pc = 32'hDEAD_BEEF; exc_illegal = 1'b1; exc_imisalign = 1'b0;
        #3;
        if (sb.size() != 0) check("drain_flags", {29'd0, busy, stall, flush}, 32'd7);
      end else if (j == 2) begin
        ex_valid = 1'b0; exc_illegal = 1'b0;
      end
      if (j == 2) {exc_smisalign, exc_lmisalign, exc_ecall, exc_ebreak, exc_imisalign} = '0;
      if (j == 2) {ex_mret, ex_sret, irq_enable, irq_ext, irq_timer} = '0;
      if (j == busy_n + 1) mem_busy = 1'b0;
    end
    ex_valid = 1'b0; exc_illegal = 1'b0; mem_busy = 1'b0;
    if (sb.size() != 0) begin
      check("sequence_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    #3;
    check("reset_outputs", {25'd0, busy, stall, flush, trap_take, mret, sret, redirect_valid}, 32'd0);
    check("reset_trap_pc", trap_pc, 32'd0);
    check("reset_redirect_pc", redirect_pc, 32'd0);
    #18 rst = 1'b0;
    @(posedge clk); #1;

    //   v  exc{sm,lm,ec,eb,il,im} m  s  priv   pc        tv        ra     busy irq{en,ext,tmr}
    send(1, 6'b000010, 0, 0, 2'b11, 32'h100, 32'h200,  32'h0,   0, 3'b000); // illegal
    send(1, 6'b011000, 0, 0, 2'b00, 32'h104, 32'h1003, 32'h0,   0, 3'b000); // ecall U + lmis
    send(1, 6'b000000, 1, 0, 2'b11, 32'h108, 32'h200,  32'h344, 0, 3'b000); // mret M
    send(1, 6'b000000, 0, 1, 2'b00, 32'h10C, 32'h400,  32'h55C, 0, 3'b000); // sret U
    send(1, 6'b000010, 0, 0, 2'b11, 32'h110, 32'h200,  32'h0,  10, 3'b000); // drain timeout
    send(1, 6'b100000, 0, 0, 2'b11, 32'h114, 32'h300,  32'h0,   2, 3'b000); // short busy
    send(1, 6'b001000, 0, 0, 2'b01, 32'h118, 32'h300,  32'h0,   0, 3'b000); // ecall S
    send(1, 6'b000000, 0, 1, 2'b01, 32'h11C, 32'h300,  32'h720, 0, 3'b000); // sret S
    send(1, 6'b000000, 1, 0, 2'b01, 32'h120, 32'h300,  32'h0,   0, 3'b000); // mret S
    send(1, 6'b000011, 0, 0, 2'b11, 32'h124, 32'h300,  32'h0,   0, 3'b000); // imis > illegal
    send(1, 6'b001100, 0, 0, 2'b11, 32'h128, 32'h300,  32'h0,   0, 3'b000); // ebreak > ecall
    send(1, 6'b001000, 0, 0, 2'b11, 32'h12C, 32'h300,  32'h0,   0, 3'b000); // ecall M
    send(1, 6'b100000, 0, 0, 2'b11, 32'h130, 32'h300,  32'h0,   0, 3'b000); // smisalign
    send(0, 6'b000010, 0, 0, 2'b11, 32'h134, 32'h300,  32'h0,   0, 3'b000); // ex_valid=0
    send(1, 6'b000000, 0, 0, 2'b11, 32'h138, 32'h201,  32'h0,   0, 3'b101); // timer irq
    send(1, 6'b000000, 1, 0, 2'b11, 32'h13C, 32'h201,  32'h344, 0, 3'b111); // ext irq vs mret

    // Reset mid-DRAIN: outputs clear at once and the trap never commits.
    ex_valid = 1'b1; ex_pc = 32'h140; exc_illegal = 1'b1; mem_busy = 1'b1;
    @(posedge clk); #1;
    ex_valid = 1'b0; exc_illegal = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_async_flags", {25'd0, busy, stall, flush, trap_take, mret, sret, redirect_valid}, 32'd0);
    check("rst_async_trap_pc", trap_pc, 32'd0);
    #2 rst = 1'b0; mem_busy = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("after_rst_idle", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
